// File: rtl/seq_pkg.sv
// Shared types for the "1011" serializer/detector pair: Gray-coded FSM state
// and the default word width.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_e;

  localparam int SEQ_WORD_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sequence_serializer.sv
// Parallel-to-serial feeder for the "1011" detector, MSB-first with gapless
// back-to-back words. Define SERIALIZER_PARITY_EN to append an even-parity bit.
//
// state | meaning
// IDLE  | no word held; line low, ready for a word
// SHIFT | emitting a word, one bit per clock; reload allowed on its last bit
module sequence_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WORD_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             sequence_out,
  output logic             sequence_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SERIALIZER_PARITY_EN
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
`endif

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit;
  logic             xfer;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`endif

  // Ready never looks at data_valid, so upstream can safely gate valid on ready.
  always_comb begin
    last_bit   = (state_q == SHIFT) && (cnt_q == '0);
    data_ready = !reset && ((state_q == IDLE) || last_bit);
    xfer       = data_valid && data_ready;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          shift_d = data_in;
          cnt_d   = CNT_LOAD;
`ifdef SERIALIZER_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (xfer) begin
            shift_d = data_in;
            cnt_d   = CNT_LOAD;
`ifdef SERIALIZER_PARITY_EN
            parity_d = ^data_in;
`endif
          end else begin
            state_d = IDLE;
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy           = (state_q == SHIFT);
    sequence_valid = busy;
    word_done      = last_bit;
`ifdef SERIALIZER_PARITY_EN
    sequence_out   = busy && (last_bit ? parity_q : shift_q[WIDTH-1]);
`else
    sequence_out   = busy && shift_q[WIDTH-1];
`endif
  end

endmodule

// File: tb/tb_sequence_serializer.sv
// Self-checking bench for sequence_serializer: literal vector table, directed
// corner sequences and random traffic against a bit-queue reference model.
module tb_sequence_serializer;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready, sequence_out, sequence_valid, busy, word_done;

  int total = 0;
  int bad   = 0;
  bit q[$];

  sequence_serializer #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .sequence_out  (sequence_out),
    .sequence_valid(sequence_valid),
    .busy          (busy),
    .word_done     (word_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] bits;
    logic         par;
  } vec_t;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: the queue holds bits still to appear on the line; its head is
  // the bit visible this cycle.
  task automatic push_word(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
    q.push_back(^d);
`endif
  endtask

  task automatic check_model();
    bit has;
    has = (q.size() != 0);
    chk("sequence_out", sequence_out, has ? q[0] : 1'b0);
    chk("sequence_valid", sequence_valid, has);
    chk("busy", busy, has);
    chk("word_done", word_done, q.size() == 1);
    chk("data_ready", data_ready, q.size() <= 1);
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d);
    bit rdy;
    data_valid = v;
    data_in    = d;
    rdy        = (q.size() <= 1);
    @(posedge clock);
    if (q.size() != 0) void'(q.pop_front());
    if (v && rdy) push_word(d);
    @(negedge clock);
    check_model();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out"}, sequence_out, 1'b0);
    chk({tag, "_valid"}, sequence_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, word_done, 1'b0);
    chk({tag, "_ready"}, data_ready, 1'b0);
  endtask

  vec_t tbl[6];
  logic [W-1:0] b;
  logic [31:0]  stream;
  logic [31:0]  exp_stream;
  int           nbits, ndone;

  initial begin
    tbl[0] = '{din: 8'hB4, bits: 8'b10110100, par: 1'b0};
    tbl[1] = '{din: 8'h0F, bits: 8'b00001111, par: 1'b0};
    tbl[2] = '{din: 8'hFF, bits: 8'b11111111, par: 1'b0};
    tbl[3] = '{din: 8'h01, bits: 8'b00000001, par: 1'b1};
    tbl[4] = '{din: 8'hB5, bits: 8'b10110101, par: 1'b1};
    tbl[5] = '{din: 8'h80, bits: 8'b10000000, par: 1'b1};

    reset      = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'hA5;
    repeat (3) @(negedge clock);
    chk_reset_outputs("in_reset");
    reset = 1'b0;
    data_valid = 1'b0;
    @(negedge clock);
    check_model();

    // Single words from the literal table, data_in scrambled while busy.
    for (int k = 0; k < 6; k++) begin
      b = tbl[k].bits;
      cycle(1'b1, tbl[k].din);
      for (int i = 0; i < NB; i++) begin
        chk("tbl_bit", sequence_out, (i < W) ? b[W-1-i] : tbl[k].par);
        chk("tbl_done", word_done, i == NB - 1);
        chk("tbl_ready", data_ready, i == NB - 1);
        cycle(1'b0, W'($urandom));
      end
      chk("tbl_idle", sequence_valid, 1'b0);
    end

    // Back-to-back with data_valid held high.
    stream = '0; nbits = 0; ndone = 0;
    cycle(1'b1, 8'hB0);
    for (int i = 0; i < 2 * NB; i++) begin
      if (sequence_valid) begin
        stream = {stream[30:0], sequence_out};
        nbits++;
      end
      if (word_done) ndone++;
      cycle(i < NB, 8'h0B);
    end
`ifdef SERIALIZER_PARITY_EN
    exp_stream = 32'b101100001_000010111;
`else
    exp_stream = 32'b10110000_00001011;
`endif
    chk_int("b2b_stream", int'(stream), int'(exp_stream));
    chk_int("b2b_nbits", nbits, 2 * NB);
    chk_int("b2b_ndone", ndone, 2);

    // Idle, then backpressure: valid held with changing data during the word.
    repeat (10) cycle(1'b0, W'($urandom));
    cycle(1'b1, 8'hFF);
    repeat (NB - 1) cycle(1'b1, W'($urandom));
    repeat (2) cycle(1'b0, '0);

    // Asynchronous reset after three bits of B4.
    cycle(1'b1, 8'hB4);
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    chk("pre_reset_bit", sequence_out, 1'b1);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("mid_reset");
    q.delete();
    @(negedge clock);
    chk_reset_outputs("held_reset");
    reset = 1'b0;
    @(negedge clock);
    check_model();
    stream = '0;
    cycle(1'b1, 8'h0F);
    for (int i = 0; i < W; i++) begin
      stream = {stream[30:0], sequence_out};
      cycle(1'b0, '0);
    end
    chk_int("post_reset_word", int'(stream[7:0]), 8'h0F);
    repeat (NB) cycle(1'b0, '0);

    // Random traffic against the queue model.
    for (int n = 0; n < 600; n++)
      cycle($urandom_range(0, 3) != 0, W'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
